// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module : rc4_pkg
// Brief  : Shared state encoding and constants for the RC4 KSA engine.
// Rev    : 1.0
// ============================================================================
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        INIT  = 4'd1,
        RD_I  = 4'd2,
        GET_I = 4'd3,
        RD_J  = 4'd4,
        GET_J = 4'd5,
        WR_I  = 4'd6,
        WR_J  = 4'd7,
        DONE  = 4'd8
    } state_t;

    localparam int KSA_CYCLES_PER_I  = 6;
    localparam int KEY_BYTES_DEFAULT = 3;

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/rc4_key_byte_sel.sv
`default_nettype none
// ============================================================================
// Module : rc4_key_byte_sel
// Brief  : key_idx wrap counter and key byte mux (byte 0 is the MS byte).
// Rev    : 1.0
// ============================================================================
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [7:0]             key_byte
);

    localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_BYTES - 1);

    logic [IDX_W-1:0] key_idx;

    // Wrap counter stands in for i mod KEY_BYTES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_idx <= '0;
        end else if (clear) begin
            key_idx <= '0;
        end else if (advance) begin
            key_idx <= (key_idx == IDX_LAST) ? '0 : key_idx + IDX_W'(1);
        end
    end

    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (key_idx == IDX_W'(k)) begin
                key_byte = secret_key[8*(KEY_BYTES-k)-1 -: 8];
            end
        end
    end

endmodule : rc4_key_byte_sel
`default_nettype wire

// File: rtl/rc4_ksa_engine.sv
`default_nettype none
// ============================================================================
// Module : rc4_ksa_engine
// Brief  : Fills S with s[i]=i, then optionally runs the RC4 key schedule.
// Rev    : 1.0
// ============================================================================
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   init_only,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [DATA_W-1:0]      q,
    output logic [DATA_W-1:0]      address,
    output logic [DATA_W-1:0]      data,
    output logic                   wen,
    output logic                   busy,
    output logic                   finito
);

    localparam logic [DATA_W-1:0] I_LAST = '1;
    localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   i;
    logic [DATA_W-1:0]   j;
    logic [DATA_W-1:0]   si;
    logic [DATA_W-1:0]   sj;
    logic                mode_init_only;
    logic                key_clear;
    logic                key_advance;
    logic [7:0]          key_byte;
    logic [DATA_W-1:0]   key_add;

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (key_clear),
        .advance    (key_advance),
        .secret_key (secret_key),
        .key_byte   (key_byte)
    );

    generate
        if (DATA_W <= 8) begin : g_key_narrow
            assign key_add = key_byte[DATA_W-1:0];
        end else begin : g_key_wide
            assign key_add = {{(DATA_W-8){1'b0}}, key_byte};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        address     = '0;
        data        = '0;
        wen         = 1'b0;
        key_clear   = 1'b0;
        key_advance = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                    key_clear  = 1'b1;
                end
            end
            INIT: begin
                address = i;
                data    = i;
                wen     = 1'b1;
                if (i == I_LAST) begin
                    state_next = mode_init_only ? DONE : RD_I;
                    key_clear  = 1'b1;
                end
            end
            RD_I:  begin address = i; state_next = GET_I; end
            GET_I: begin address = i; state_next = RD_J;  end
            RD_J:  begin address = j; state_next = GET_J; end
            GET_J: begin address = j; state_next = WR_I;  end
            // When i==j both writes carry the same value, so the entry survives.
            WR_I: begin
                address    = i;
                data       = sj;
                wen        = 1'b1;
                state_next = WR_J;
            end
            WR_J: begin
                address     = j;
                data        = si;
                wen         = 1'b1;
                key_advance = 1'b1;
                state_next  = (i == I_LAST) ? DONE : RD_I;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i              <= '0;
            j              <= '0;
            si             <= '0;
            sj             <= '0;
            mode_init_only <= 1'b0;
            busy           <= 1'b0;
            finito         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i              <= '0;
                        j              <= '0;
                        mode_init_only <= init_only;
                        busy           <= 1'b1;
                        finito         <= 1'b0;
                    end
                end
                INIT: begin
                    i <= i + ONE;
                    j <= '0;
                end
                GET_I: begin
                    si <= q;
                    j  <= j + q + key_add;
                end
                GET_J: sj <= q;
                WR_J:  i  <= i + ONE;
                DONE: begin
                    busy   <= 1'b0;
                    finito <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : rc4_ksa_engine
`default_nettype wire

// File: tb/tb_rc4_ksa_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_rc4_ksa_engine
// Brief  : Directed bench for rc4_ksa_engine (DATA_W=8/KEY_BYTES=3 and DATA_W=2/KEY_BYTES=1).
// Rev    : 1.0
// ============================================================================
module tb_rc4_ksa_engine;

    logic clk;
    logic reset_n;
    logic scrub;

    // 8-bit instance
    logic        start8, init_only8, wen8, busy8, finito8;
    logic [23:0] key8;
    logic [7:0]  q8, addr8, data8;
    logic [7:0]  mem8 [256];

    // 2-bit instance
    logic        start2, init_only2, wen2, busy2, finito2;
    logic [7:0]  key2;
    logic [1:0]  q2, addr2, data2;
    logic [1:0]  mem2 [4];

    logic [7:0]  gold [256];

    logic [7:0]  w8a [1024];
    logic [7:0]  w8d [1024];
    int          w8cnt;
    logic [3:0]  w2log [64];
    int          w2cnt;

    int n_checks;
    int n_pass;

    rc4_ksa_engine #(.DATA_W(8), .KEY_BYTES(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .init_only(init_only8),
        .secret_key(key8), .q(q8), .address(addr8), .data(data8),
        .wen(wen8), .busy(busy8), .finito(finito8)
    );

    rc4_ksa_engine #(.DATA_W(2), .KEY_BYTES(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .init_only(init_only2),
        .secret_key(key2), .q(q2), .address(addr2), .data(data2),
        .wen(wen2), .busy(busy2), .finito(finito2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAMs with one-cycle read latency
    always @(posedge clk) begin
        if (scrub) begin
            for (int k = 0; k < 256; k++) mem8[k] <= 8'hA5;
        end else if (wen8) begin
            mem8[addr8] <= data8;
        end
        q8 <= mem8[addr8];
    end

    always @(posedge clk) begin
        if (scrub) begin
            for (int k = 0; k < 4; k++) mem2[k] <= 2'd2;
        end else if (wen2) begin
            mem2[addr2] <= data2;
        end
        q2 <= mem2[addr2];
    end

    always @(negedge clk) begin
        if (wen8) begin
            if (w8cnt < 1024) begin
                w8a[w8cnt] = addr8;
                w8d[w8cnt] = data8;
            end
            w8cnt++;
        end
        if (wen2) begin
            if (w2cnt < 64) w2log[w2cnt] = {addr2, data2};
            w2cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic gold_ksa(input logic [23:0] key);
        logic [7:0] j, t, kb;
        j = 8'd0;
        for (int k = 0; k < 256; k++) gold[k] = k[7:0];
        for (int k = 0; k < 256; k++) begin
            case (k % 3)
                0:       kb = key[23:16];
                1:       kb = key[15:8];
                default: kb = key[7:0];
            endcase
            j       = j + gold[k] + kb;
            t       = gold[k];
            gold[k] = gold[j];
            gold[j] = t;
        end
    endtask

    function automatic int ram8_vs_gold();
        int bad = 0;
        for (int k = 0; k < 256; k++) if (mem8[k] !== gold[k]) bad++;
        return bad;
    endfunction

    task automatic pulse8(input logic mode);
        @(posedge clk);
        #1;
        w8cnt      = 0;
        init_only8 = mode;
        start8     = 1'b1;
        @(posedge clk);
        #1;
        start8     = 1'b0;
    endtask

    task automatic pulse2(input logic mode);
        @(posedge clk);
        #1;
        w2cnt      = 0;
        init_only2 = mode;
        start2     = 1'b1;
        @(posedge clk);
        #1;
        start2     = 1'b0;
    endtask

    task automatic wait_finito8(output int cyc);
        cyc = 0;
        while (!finito8 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Optionally re-pulses start a few cycles into the pass to prove it is ignored.
    task automatic wait_finito2(input bit inject, output int cyc);
        cyc = 0;
        while (!finito2 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject && cyc == 3) start2 = 1'b1;
            if (cyc == 4) start2 = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        int bad;
        n_checks = 0; n_pass = 0;
        w8cnt = 0; w2cnt = 0;
        reset_n = 1'b0; scrub = 1'b1;
        start8 = 1'b0; init_only8 = 1'b0; key8 = 24'h000249;
        start2 = 1'b0; init_only2 = 1'b0; key2 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        scrub = 1'b0;
        check("rst_address", 32'(addr8), 32'h0);
        check("rst_data",    32'(data8), 32'h0);
        check("rst_wen",     32'(wen8), 32'h0);
        check("rst_busy",    32'(busy8), 32'h0);
        check("rst_finito",  32'(finito8), 32'h0);
        check("rst_busy2",   32'(busy2), 32'h0);
        #3 reset_n = 1'b1;

        // Init only, DATA_W=8
        pulse8(1'b1);
        check("init_busy", 32'(busy8), 32'h1);
        wait_finito8(cyc);
        check("init_latency", cyc, 257);
        check("init_busy_done", 32'(busy8), 32'h0);
        check("init_writes", w8cnt, 256);
        bad = 0;
        for (int k = 0; k < 256; k++)
            if (w8a[k] !== k[7:0] || w8d[k] !== k[7:0]) bad++;
        check("init_write_seq", bad, 0);
        @(posedge clk);
        #1;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem8[k] !== k[7:0]) bad++;
        check("init_ram", bad, 0);

        // Full KSA, DATA_W=2, key 00, with a start pulse during busy
        key2 = 8'h00;
        pulse2(1'b0);
        wait_finito2(1'b1, cyc);
        check("k00_latency", cyc, 29);
        check("k00_pair_i2_wr_i", 32'(w2log[8]), 32'b10_11);
        check("k00_pair_i2_wr_j", 32'(w2log[9]), 32'b11_10);
        @(posedge clk);
        #1;
        check("k00_ram", {mem2[0], mem2[1], mem2[2], mem2[3]}, 8'b00_10_11_01);

        // Key 01, started while finito=1
        key2 = 8'h01;
        pulse2(1'b0);
        check("restart_finito_drop", 32'(finito2), 32'h0);
        check("restart_busy", 32'(busy2), 32'h1);
        wait_finito2(1'b0, cyc);
        check("k01_latency", cyc, 29);
        check("k01_pair_i0_wr_i", 32'(w2log[4]), 32'b00_01);
        check("k01_pair_i0_wr_j", 32'(w2log[5]), 32'b01_00);
        @(posedge clk);
        #1;
        check("k01_ram", {mem2[0], mem2[1], mem2[2], mem2[3]}, 8'b00_10_11_01);

        // Full KSA, DATA_W=8, key 000249
        gold_ksa(24'h000249);
        key8 = 24'h000249;
        pulse8(1'b0);
        wait_finito8(cyc);
        check("ksa8_latency", cyc, 1793);
        check("ksa8_writes", w8cnt, 768);
        @(posedge clk);
        #1;
        check("ksa8_ram", ram8_vs_gold(), 0);

        // Restart from finito, then reset during the WR_I cycle of i=100
        pulse8(1'b0);
        check("ksa8_restart_finito", 32'(finito8), 32'h0);
        repeat (860) @(posedge clk);
        #1;
        check("mid_wen_pre",  32'(wen8), 32'h1);
        check("mid_addr_pre", 32'(addr8), 32'd100);
        check("mid_busy_pre", 32'(busy8), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_wen",    32'(wen8), 32'h0);
        check("mid_rst_busy",   32'(busy8), 32'h0);
        check("mid_rst_finito", 32'(finito8), 32'h0);
        check("mid_rst_addr",   32'(addr8), 32'h0);
        #13 reset_n = 1'b1;

        pulse8(1'b0);
        wait_finito8(cyc);
        check("post_rst_latency", cyc, 1793);
        @(posedge clk);
        #1;
        check("post_rst_ram", ram8_vs_gold(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rc4_ksa_engine
`default_nettype wire

// File: doc/rc4_ksa_engine.md
Name: rc4_ksa_engine

Overview:
Parametrised successor to the task-1 S-box initialiser. On a start pulse it fills the S memory with s[i]=i, then optionally runs the full RC4 key-scheduling pass (j += s[i] + key[i mod KEY_BYTES]; swap s[i], s[j]) against the same single-port RAM. It sits between the top-level controller and the S-memory RAM, ahead of the PRGA/decrypt stage, and raises finito when S is ready.

Parameters:
DATA_W, 8, byte/address width; the S memory holds N = 2**DATA_W entries
KEY_BYTES, 3, secret key length in bytes (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
init_only  in  1  sampled with start; 1 = stop after init, 0 = init + key schedule
secret_key  in  8*KEY_BYTES  key; byte k = secret_key[8*(KEY_BYTES-k)-1 -: 8] (byte 0 is MS byte)
q  in  DATA_W  RAM read data; valid in the cycle after its address was presented
address  out  DATA_W  RAM address
data  out  DATA_W  RAM write data
wen  out  1  RAM write enable
busy  out  1  high from the cycle after an accepted start until finito rises
finito  out  1  high from completion until the next accepted start

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; address=0, data=0, wen=0, busy=0, finito=0; i, j, key_idx, si, sj cleared. Reset mid-pass abandons the pass; RAM contents are undefined and the pass is not resumed.
- IDLE: start=1 -> INIT with i=0, finito cleared, mode latched. start=0 -> hold. A start while busy is ignored. A start while finito=1 restarts the pass.
- INIT: address=i, data=i, wen=1 each cycle. When i==N-1: if init_only -> DONE, else -> RD_I with i=0, j=0, key_idx=0. INIT takes N cycles.
- KSA loop, 6 cycles per i:
  RD_I: address=i, wen=0.
  GET_I: si<=q; j<=j+q+key_byte[key_idx], modulo 2**DATA_W (truncate the 8-bit key byte to DATA_W).
  RD_J: address=j.
  GET_J: sj<=q.
  WR_I: address=i, data=sj, wen=1.
  WR_J: address=j, data=si, wen=1. key_idx wraps KEY_BYTES-1 -> 0. When i==N-1 -> DONE, else i+1 -> RD_I.
- i==j: both writes target the same address with equal data. Required result: the entry is unchanged.
- key_idx uses a wrap counter, not a divider or modulo.
- DONE: wen=0, finito=1, busy=0 -> IDLE. finito stays high in IDLE until the next start.
- wen is high only in INIT, WR_I and WR_J.
- Latency from start to finito: N+1 cycles (init_only) or 7N+1 cycles (full). For DATA_W=8 these are 257 and 1793.

Decomposition:
- Package rc4_pkg holds the state enum (IDLE, INIT, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE) and the constants KSA_CYCLES_PER_I=6 and the default key length.
- A single sub-module, rc4_key_byte_sel, provides the key_idx wrap counter and the byte mux from secret_key.
- The FSM and datapath stay in rc4_ksa_engine.
- The bench uses a behavioural 1-cycle-read RAM model.

Test Plan:
- Init only, DATA_W=8, init_only=1, single start -> 256 consecutive writes with address=data=0..255; finito rises 257 cycles after start; RAM dump shows s[k]=k.
- Full KSA, DATA_W=2, KEY_BYTES=1, key=8'h00 -> final S=[0,1,3,2] after i=2, then [0,2,3,1]; finito rises 29 cycles after start.
- Full KSA, DATA_W=2, KEY_BYTES=1, key=8'h01 -> final S=[0,2,3,1]; the i=0 write pair is addr0<=1, addr1<=0.
- Full KSA, DATA_W=8, KEY_BYTES=3, key=24'h000249 -> RAM matches the golden software KSA; key bytes are applied in order 00,02,49 repeating; finito at 1793 cycles.
- Reset mid-pass: assert reset_n=0 during the KSA at i=100 -> wen, busy and finito go to 0 immediately. A new start after release -> a clean full pass matching golden.
- start pulsed during busy is ignored (latency unchanged). start while finito=1 -> finito drops next cycle and the pass reruns.
